// File: rtl/mem_stage_if.sv
// EX->MS, SRAM read-data and MS->WB signals of the memory stage.
// The slave modport is the stage itself; master is the surrounding pipeline.
interface mem_stage_if #(
  parameter int EXZ_W = 86
);
  logic             es_to_ms_valid;
  logic             ms_allowin;
  logic [31:0]      es_pc;
  logic             es_rf_we;
  logic [4:0]       es_rf_waddr;
  logic [31:0]      es_result;
  logic             es_res_from_mem;
  logic [4:0]       es_ld_inst;
  logic             es_csr_re;
  logic [EXZ_W-1:0] es_ex_zip;
  logic [31:0]      data_sram_rdata;
  logic             ws_allowin;
  logic             wb_ex;
  logic             ms_to_ws_valid;
  logic [31:0]      ms_pc;
  logic             ms_rf_we;
  logic [4:0]       ms_rf_waddr;
  logic [31:0]      ms_final_result;
  logic [31:0]      ms_vaddr;
  logic             ms_res_from_mem;
  logic             ms_csr_re;
  logic [EXZ_W-1:0] ms_ex_zip;
  logic             ms_ex;

  modport slave (
    input  es_to_ms_valid, es_pc, es_rf_we, es_rf_waddr, es_result,
           es_res_from_mem, es_ld_inst, es_csr_re, es_ex_zip,
           data_sram_rdata, ws_allowin, wb_ex,
    output ms_allowin, ms_to_ws_valid, ms_pc, ms_rf_we, ms_rf_waddr,
           ms_final_result, ms_vaddr, ms_res_from_mem, ms_csr_re,
           ms_ex_zip, ms_ex
  );

  modport master (
    output es_to_ms_valid, es_pc, es_rf_we, es_rf_waddr, es_result,
           es_res_from_mem, es_ld_inst, es_csr_re, es_ex_zip,
           data_sram_rdata, ws_allowin, wb_ex,
    input  ms_allowin, ms_to_ws_valid, ms_pc, ms_rf_we, ms_rf_waddr,
           ms_final_result, ms_vaddr, ms_res_from_mem, ms_csr_re,
           ms_ex_zip, ms_ex
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage between EX and WB. Holds the EX result,
// picks up the SRAM word the cycle after entry, extends load data and keeps
// that word in a buffer while WB stalls so the result never drifts.
module mem_stage #(
  parameter int EXZ_W = 86
) (
  input logic         clk,
  input logic         resetn,
  mem_stage_if.slave  bus
);

  logic             r_ms_valid;
  logic [31:0]      r_pc;
  logic             r_rf_we;
  logic [4:0]       r_rf_waddr;
  logic [31:0]      r_vaddr;
  logic             r_res_from_mem;
  logic [4:0]       r_ld_inst;
  logic             r_csr_re;
  logic [EXZ_W-1:0] r_ex_zip;
  logic             r_first;
  logic [31:0]      r_rbuf;
  logic             r_rbuf_valid;

  logic             w_ms_allowin;
  logic             w_load;
  logic             w_ms_ex;
  logic [31:0]      w_rdata_sel;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_ext;

  // The stage never needs extra cycles, so it frees up as soon as WB takes it.
  assign w_ms_allowin = ~r_ms_valid | bus.ws_allowin;
  assign w_load       = bus.es_to_ms_valid & w_ms_allowin & ~bus.wb_ex;
  // Any recorded exception, including ertn, must block younger stores in EX.
  assign w_ms_ex      = r_ms_valid & (|r_ex_zip[6:0]);

  // Valid bit: a WB flush empties the stage before anything else is considered.
  always_ff @(posedge clk) begin
    if (!resetn)          r_ms_valid <= 1'b0;
    else if (bus.wb_ex)   r_ms_valid <= 1'b0;
    else if (w_ms_allowin) r_ms_valid <= bus.es_to_ms_valid;
  end

  // Payload registers take EX values only on an accepted, unflushed handoff.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_pc           <= 32'b0;
      r_rf_we        <= 1'b0;
      r_rf_waddr     <= 5'b0;
      r_vaddr        <= 32'b0;
      r_res_from_mem <= 1'b0;
      r_ld_inst      <= 5'b0;
      r_csr_re       <= 1'b0;
      r_ex_zip       <= '0;
    end else if (w_load) begin
      r_pc           <= bus.es_pc;
      r_rf_we        <= bus.es_rf_we;
      r_rf_waddr     <= bus.es_rf_waddr;
      r_vaddr        <= bus.es_result;
      r_res_from_mem <= bus.es_res_from_mem;
      r_ld_inst      <= bus.es_ld_inst;
      r_csr_re       <= bus.es_csr_re;
      r_ex_zip       <= bus.es_ex_zip;
    end
  end

  // Marks the single cycle in which the SRAM output belongs to this instruction.
  always_ff @(posedge clk) begin
    if (!resetn) r_first <= 1'b0;
    else         r_first <= w_load;
  end

  // Read buffer: keeps the first-cycle word while WB holds the stage.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rbuf       <= 32'b0;
      r_rbuf_valid <= 1'b0;
    end else if (bus.wb_ex) begin
      r_rbuf_valid <= 1'b0;
    end else if (r_first & ~bus.ws_allowin) begin
      r_rbuf       <= bus.data_sram_rdata;
      r_rbuf_valid <= 1'b1;
    end else if (r_ms_valid & bus.ws_allowin) begin
      r_rbuf_valid <= 1'b0;
    end
  end

  // A stale buffer is never selected; after the first cycle a live load always has it filled.
  assign w_rdata_sel = r_first      ? bus.data_sram_rdata :
                       r_rbuf_valid ? r_rbuf : 32'b0;

  // Lane selection and sign/zero extension for the load width in flight.
  always_comb begin
    w_byte = w_rdata_sel[7:0];
    case (r_vaddr[1:0])
      2'd1:    w_byte = w_rdata_sel[15:8];
      2'd2:    w_byte = w_rdata_sel[23:16];
      2'd3:    w_byte = w_rdata_sel[31:24];
      default: w_byte = w_rdata_sel[7:0];
    endcase
    w_half = r_vaddr[1] ? w_rdata_sel[31:16] : w_rdata_sel[15:0];
    w_ext  = w_rdata_sel;
    if (r_ld_inst[4])      w_ext = {{24{w_byte[7]}}, w_byte};
    else if (r_ld_inst[3]) w_ext = {24'b0, w_byte};
    else if (r_ld_inst[2]) w_ext = {{16{w_half[15]}}, w_half};
    else if (r_ld_inst[1]) w_ext = {16'b0, w_half};
    else if (r_ld_inst[0]) w_ext = w_rdata_sel;
  end

  assign bus.ms_allowin      = w_ms_allowin;
  assign bus.ms_to_ws_valid  = r_ms_valid;
  assign bus.ms_pc           = r_pc;
  assign bus.ms_rf_we        = r_ms_valid & r_rf_we & ~w_ms_ex;
  assign bus.ms_rf_waddr     = r_rf_waddr;
  assign bus.ms_final_result = r_res_from_mem ? w_ext : r_vaddr;
  assign bus.ms_vaddr        = r_vaddr;
  assign bus.ms_res_from_mem = r_ms_valid & r_res_from_mem;
  assign bus.ms_csr_re       = r_csr_re;
  assign bus.ms_ex_zip       = r_ex_zip;
  assign bus.ms_ex           = w_ms_ex;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios followed by random traffic
// compared against a transaction-level model of the stage.
module tb_mem_stage;
  localparam int EXZ_W = 86;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  mem_stage_if #(.EXZ_W(EXZ_W)) bus ();
  mem_stage #(.EXZ_W(EXZ_W)) dut (.clk(clk), .resetn(resetn), .bus(bus.slave));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic chkz(input string tag, input logic [EXZ_W-1:0] obs, input logic [EXZ_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic ex_idle();
    bus.es_to_ms_valid  = 1'b0;
    bus.es_pc           = 32'b0;
    bus.es_rf_we        = 1'b0;
    bus.es_rf_waddr     = 5'b0;
    bus.es_result       = 32'b0;
    bus.es_res_from_mem = 1'b0;
    bus.es_ld_inst      = 5'b0;
    bus.es_csr_re       = 1'b0;
    bus.es_ex_zip       = '0;
  endtask

  task automatic ex_set(input logic [31:0] pc, input logic [31:0] res, input logic load,
                        input logic [4:0] ld, input logic we, input logic [4:0] waddr,
                        input logic [EXZ_W-1:0] zip);
    bus.es_to_ms_valid  = 1'b1;
    bus.es_pc           = pc;
    bus.es_rf_we        = we;
    bus.es_rf_waddr     = waddr;
    bus.es_result       = res;
    bus.es_res_from_mem = load;
    bus.es_ld_inst      = ld;
    bus.es_csr_re       = 1'b0;
    bus.es_ex_zip       = zip;
  endtask

  // Load result from the architectural rule: pick the addressed byte/half, then extend.
  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] lane,
                                           input logic [4:0] ld);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * int'(lane))) & 32'h0000_00FF;
    h = lane[1] ? (w >> 16) : (w & 32'h0000_FFFF);
    h = h & 32'h0000_FFFF;
    case (ld)
      5'b10000: return b[7]  ? (b | 32'hFFFF_FF00) : b;
      5'b01000: return b;
      5'b00100: return h[15] ? (h | 32'hFFFF_0000) : h;
      5'b00010: return h;
      default:  return w;
    endcase
  endfunction

  // Model state: the instruction currently held in MS and the word it loaded.
  logic             m_valid;
  logic [31:0]      m_pc, m_addr, m_word;
  logic             m_we, m_load, m_csr;
  logic [4:0]       m_waddr, m_ld;
  logic [EXZ_W-1:0] m_zip;
  int               m_age;

  initial begin
    logic [31:0]      alu_res [4];
    logic [31:0]      data;
    logic [EXZ_W-1:0] zip_r;
    logic             exp_ex;
    logic             ev;
    logic             ld_sel;

    ex_idle();
    bus.data_sram_rdata = 32'b0;
    bus.ws_allowin      = 1'b1;
    bus.wb_ex           = 1'b0;
    resetn              = 1'b0;

    // Reset state
    cyc(); cyc(); settle();
    chk1 ("rst_valid",   bus.ms_to_ws_valid, 1'b0);
    chk1 ("rst_allowin", bus.ms_allowin, 1'b1);
    chk32("rst_pc",      bus.ms_pc, 32'h0);
    chk1 ("rst_rf_we",   bus.ms_rf_we, 1'b0);
    chk32("rst_final",   bus.ms_final_result, 32'h0);
    chk32("rst_vaddr",   bus.ms_vaddr, 32'h0);
    chk1 ("rst_ex",      bus.ms_ex, 1'b0);
    chkz ("rst_zip",     bus.ms_ex_zip, '0);
    chk1 ("rst_ldflag",  bus.ms_res_from_mem, 1'b0);
    chk1 ("rst_csr_re",  bus.ms_csr_re, 1'b0);

    // ld.b from lane 1, sign-extended
    cyc(); resetn = 1'b1;
    ex_set(32'h1C00_0000, 32'h0000_1001, 1'b1, 5'b10000, 1'b1, 5'd5, '0);
    cyc(); ex_idle(); bus.data_sram_rdata = 32'h1234_80FF; settle();
    chk32("ldb_final", bus.ms_final_result, 32'hFFFF_FF80);
    chk1 ("ldb_rf_we", bus.ms_rf_we, 1'b1);
    chk1 ("ldb_ldflag", bus.ms_res_from_mem, 1'b1);
    chk32("ldb_waddr", 32'(bus.ms_rf_waddr), 32'd5);

    // ld.hu then ld.h on lane 2, back to back
    cyc(); ex_set(32'h1C00_0004, 32'h0000_2002, 1'b1, 5'b00010, 1'b1, 5'd6, '0);
    cyc(); ex_set(32'h1C00_0008, 32'h0000_2002, 1'b1, 5'b00100, 1'b1, 5'd7, '0);
    bus.data_sram_rdata = 32'h9ABC_0000; settle();
    chk32("ldhu_final", bus.ms_final_result, 32'h0000_9ABC);
    cyc(); ex_idle(); bus.data_sram_rdata = 32'h9ABC_0000; settle();
    chk32("ldh_final", bus.ms_final_result, 32'hFFFF_9ABC);
    chk32("ldh_pc", bus.ms_pc, 32'h1C00_0008);

    // ld.w held for three cycles while the SRAM output moves on
    cyc(); ex_set(32'h1C00_0010, 32'h0000_3000, 1'b1, 5'b00001, 1'b1, 5'd8, '0);
    cyc(); ex_idle(); bus.ws_allowin = 1'b0; bus.data_sram_rdata = 32'h0BAD_F00D; settle();
    chk32("stall_c1", bus.ms_final_result, 32'h0BAD_F00D);
    cyc(); bus.data_sram_rdata = 32'hDEAD_BEEF; settle();
    chk32("stall_c2", bus.ms_final_result, 32'h0BAD_F00D);
    chk1 ("stall_allowin", bus.ms_allowin, 1'b0);
    cyc(); settle();
    chk32("stall_c3", bus.ms_final_result, 32'h0BAD_F00D);
    cyc(); bus.ws_allowin = 1'b1; settle();
    chk32("stall_rel", bus.ms_final_result, 32'h0BAD_F00D);
    chk1 ("stall_rel_valid", bus.ms_to_ws_valid, 1'b1);
    cyc(); settle();
    chk1 ("stall_drained", bus.ms_to_ws_valid, 1'b0);

    // Back-to-back ALU results, one per cycle
    for (int k = 0; k < 4; k++) alu_res[k] = 32'hA5A5_0000 + 32'(k * 32'h111);
    for (int k = 0; k < 5; k++) begin
      cyc();
      if (k < 4) ex_set(32'h1C00_0100 + 32'(4 * k), alu_res[k], 1'b0, 5'b0, 1'b1, 5'(k + 1), '0);
      else       ex_idle();
      settle();
      chk1("b2b_allowin", bus.ms_allowin, 1'b1);
      if (k > 0) begin
        chk32("b2b_final", bus.ms_final_result, alu_res[k-1]);
        chk1 ("b2b_valid", bus.ms_to_ws_valid, 1'b1);
      end
    end

    // Misaligned load flagged ale, then an ertn
    cyc(); ex_set(32'h1C00_0200, 32'h0000_1003, 1'b1, 5'b00001, 1'b1, 5'd9, EXZ_W'(1));
    cyc(); ex_set(32'h1C00_0204, 32'h0000_0055, 1'b0, 5'b0, 1'b1, 5'd10, EXZ_W'(64));
    settle();
    chk1 ("ale_ex",    bus.ms_ex, 1'b1);
    chk1 ("ale_rf_we", bus.ms_rf_we, 1'b0);
    chk32("ale_vaddr", bus.ms_vaddr, 32'h0000_1003);
    cyc(); ex_idle(); settle();
    chk1 ("ertn_ex",    bus.ms_ex, 1'b1);
    chk1 ("ertn_rf_we", bus.ms_rf_we, 1'b0);
    chkz ("ertn_zip",   bus.ms_ex_zip, EXZ_W'(64));

    // Flush with MS full (buffer loaded) and EX presenting
    cyc(); ex_set(32'h1C00_0300, 32'h0000_4000, 1'b1, 5'b00001, 1'b1, 5'd11, '0);
    cyc(); ex_idle(); bus.ws_allowin = 1'b0; bus.data_sram_rdata = 32'h1111_2222; settle();
    chk1("fl_full", bus.ms_to_ws_valid, 1'b1);
    cyc(); ex_set(32'h1C00_0304, 32'h0000_0077, 1'b0, 5'b0, 1'b1, 5'd12, '0);
    bus.wb_ex = 1'b1; settle();
    chk1("fl_rbuf_pre", dut.r_rbuf_valid, 1'b1);
    cyc(); ex_idle(); bus.wb_ex = 1'b0; bus.ws_allowin = 1'b1; settle();
    chk1("fl_valid", bus.ms_to_ws_valid, 1'b0);
    chk1("fl_rbuf",  dut.r_rbuf_valid, 1'b0);
    chk1("fl_rf_we", bus.ms_rf_we, 1'b0);

    // Flush in the same cycle EX hands over into an empty stage
    cyc(); ex_set(32'h1C00_0400, 32'h0000_0099, 1'b0, 5'b0, 1'b1, 5'd13, '0);
    bus.wb_ex = 1'b1;
    cyc(); ex_idle(); bus.wb_ex = 1'b0; settle();
    chk1("drop_valid", bus.ms_to_ws_valid, 1'b0);
    chk1("drop_rf_we", bus.ms_rf_we, 1'b0);

    // Random traffic against the model
    m_valid = 1'b0; m_age = 0; m_word = 32'b0;
    m_pc = 32'b0; m_addr = 32'b0; m_we = 1'b0; m_load = 1'b0; m_csr = 1'b0;
    m_waddr = 5'b0; m_ld = 5'b0; m_zip = '0;
    for (int i = 0; i < 600; i++) begin
      cyc();
      ev     = ($urandom_range(0, 3) != 0);
      ld_sel = ($urandom_range(0, 1) != 0);
      zip_r  = {22'($urandom), $urandom, $urandom};
      if ($urandom_range(0, 7) != 0) zip_r[6:0] = 7'b0;
      bus.es_to_ms_valid  = ev;
      bus.es_pc           = $urandom;
      bus.es_rf_we        = ($urandom_range(0, 1) != 0);
      bus.es_rf_waddr     = 5'($urandom);
      bus.es_result       = $urandom;
      bus.es_res_from_mem = ld_sel;
      bus.es_ld_inst      = ld_sel ? (5'b00001 << $urandom_range(0, 4)) : 5'b0;
      bus.es_csr_re       = ($urandom_range(0, 1) != 0);
      bus.es_ex_zip       = zip_r;
      bus.ws_allowin      = ($urandom_range(0, 3) != 0);
      bus.wb_ex           = ($urandom_range(0, 15) == 0);
      bus.data_sram_rdata = $urandom;
      settle();

      exp_ex = m_valid && (m_zip[6:0] != 7'b0);
      chk1("r_allowin", bus.ms_allowin, !m_valid || bus.ws_allowin);
      chk1("r_valid",   bus.ms_to_ws_valid, m_valid);
      chk1("r_ex",      bus.ms_ex, exp_ex);
      chk1("r_rf_we",   bus.ms_rf_we, m_valid && m_we && !exp_ex);
      chk1("r_ldflag",  bus.ms_res_from_mem, m_valid && m_load);
      if (m_valid) begin
        chk32("r_pc",    bus.ms_pc, m_pc);
        chk32("r_waddr", 32'(bus.ms_rf_waddr), 32'(m_waddr));
        chk32("r_vaddr", bus.ms_vaddr, m_addr);
        chk1 ("r_csr",   bus.ms_csr_re, m_csr);
        chkz ("r_zip",   bus.ms_ex_zip, m_zip);
        if (!(m_load && m_zip[0])) begin
          data = (m_age == 0) ? bus.data_sram_rdata : m_word;
          chk32("r_final", bus.ms_final_result,
                m_load ? load_ext(data, m_addr[1:0], m_ld) : m_addr);
        end
      end

      if (bus.wb_ex) begin
        m_valid = 1'b0;
      end else if (!m_valid || bus.ws_allowin) begin
        m_valid = ev;
        if (ev) begin
          m_pc = bus.es_pc; m_addr = bus.es_result; m_we = bus.es_rf_we;
          m_waddr = bus.es_rf_waddr; m_load = bus.es_res_from_mem;
          m_ld = bus.es_ld_inst; m_csr = bus.es_csr_re; m_zip = bus.es_ex_zip;
          m_age = 0;
        end
      end else begin
        if (m_age == 0) m_word = bus.data_sram_rdata;
        m_age++;
      end
    end

    // Reset while a load is parked in the stage
    cyc(); ex_set(32'h1C00_0500, 32'h0000_5002, 1'b1, 5'b00100, 1'b1, 5'd14, '0);
    bus.wb_ex = 1'b0; bus.ws_allowin = 1'b0;
    cyc(); ex_idle(); bus.data_sram_rdata = 32'h8765_4321; settle();
    chk1("mr_pre_valid", bus.ms_to_ws_valid, 1'b1);
    cyc(); resetn = 1'b0;
    cyc(); settle();
    chk1 ("mr_valid", bus.ms_to_ws_valid, 1'b0);
    chk32("mr_pc",    bus.ms_pc, 32'h0);
    chk32("mr_final", bus.ms_final_result, 32'h0);
    chk1 ("mr_rbuf",  dut.r_rbuf_valid, 1'b0);
    resetn = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
